note_scheduler: RTL and testbench

//  Central sequencer for the four note lanes. Owns the game state (TITLE/PLAY/END) and broadcasts it.

---
 rtl/note_scheduler_pkg.sv | 22 ++
 rtl/note_chart_rom.sv | 44 ++++
 rtl/note_scheduler.sv | 143 ++++++++++++++
 tb/tb_note_scheduler.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/note_scheduler_pkg.sv
// Shared game-state encoding, lane count and small helpers for the note sequencer.
package note_scheduler_pkg;

  localparam int unsigned NUM_LANES = 4;

  // Encoding is broadcast to the lane modules; 2'b00 is never driven.
  typedef enum logic [1:0] {
    GS_TITLE = 2'b01,
    GS_PLAY  = 2'b10,
    GS_END   = 2'b11
  } game_state_t;

  function automatic logic [2:0] popcount4(input logic [NUM_LANES-1:0] v);
    logic [2:0] c;
    c = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/note_chart_rom.sv
// Beat chart: one 4-bit lane mask per beat. Addresses at or past CHART_LEN read as empty.
module note_chart_rom
  import note_scheduler_pkg::*;
#(
  parameter int unsigned CHART_LEN = 32,
  parameter int unsigned CHART_SEL = 0
) (
  input  logic [5:0]           addr,
  output logic [NUM_LANES-1:0] mask
);

  // Table lookup; CHART_SEL picks the song (0), the short bring-up chart (1) or an all-lanes stress chart (2).
  always_comb begin
    mask = '0;
    case (CHART_SEL)
      1: begin
        case (addr)
          6'd0:    mask = 4'b0001;
          6'd1:    mask = 4'b0010;
          6'd2:    mask = 4'b1100;
          default: mask = '0;
        endcase
      end
      2: mask = '1;
      default: begin
        case (addr)
          6'd0:  mask = 4'b0001;  6'd1:  mask = 4'b0010;  6'd2:  mask = 4'b0100;  6'd3:  mask = 4'b1000;
          6'd4:  mask = 4'b0011;  6'd5:  mask = 4'b0000;  6'd6:  mask = 4'b1100;  6'd7:  mask = 4'b0000;
          6'd8:  mask = 4'b0101;  6'd9:  mask = 4'b1010;  6'd10: mask = 4'b0001;  6'd11: mask = 4'b1000;
          6'd12: mask = 4'b0110;  6'd13: mask = 4'b0000;  6'd14: mask = 4'b1001;  6'd15: mask = 4'b0000;
          6'd16: mask = 4'b0010;  6'd17: mask = 4'b0100;  6'd18: mask = 4'b0010;  6'd19: mask = 4'b0001;
          6'd20: mask = 4'b1111;  6'd21: mask = 4'b0000;  6'd22: mask = 4'b0000;  6'd23: mask = 4'b1000;
          6'd24: mask = 4'b0100;  6'd25: mask = 4'b0010;  6'd26: mask = 4'b0001;  6'd27: mask = 4'b0011;
          6'd28: mask = 4'b1100;  6'd29: mask = 4'b0110;  6'd30: mask = 4'b1001;  6'd31: mask = 4'b1111;
          default: mask = '0;
        endcase
      end
    endcase
    if ({26'd0, addr} >= CHART_LEN) begin
      mask = '0;
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// Central sequencer: game state machine, beat divider, per-lane spawn arbitration and score/miss counting.
module note_scheduler
  import note_scheduler_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 250000,
  parameter int unsigned CHART_LEN = 32,
  parameter int unsigned MAX_MISS  = 8,
  parameter int unsigned SCORE_W   = 16,
  parameter int unsigned CHART_SEL = 0
) (
  input  logic               clk,
  input  logic               resetbtn,
  input  logic               start_p,
  input  logic [3:0]         lane_busy,
  input  logic [3:0]         hit_p,
  input  logic [3:0]         miss_p,
  output logic [1:0]         gamestate,
  output logic [3:0]         spawn,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         misses,
  output logic               game_over
);

  localparam int unsigned        TICK_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [6:0]         CHART_END  = 7'(CHART_LEN);
  localparam logic [7:0]         MISS_LIMIT = 8'(MAX_MISS);
  localparam logic [SCORE_W+2:0] SCORE_SAT  = {3'b000, {SCORE_W{1'b1}}};

  game_state_t         state, state_next;
  logic [TICK_W-1:0]   tick_cnt;
  logic [6:0]          beat_idx;
  logic [3:0]          pending;
  logic [3:0]          chart_mask;

  logic                beat, chart_beat, lose, finish;
  logic [3:0]          fire, held, beat_mask, overrun, pending_nx;
  logic [SCORE_W+2:0]  hit_add, score_sum;
  logic [SCORE_W-1:0]  score_nx;
  logic [9:0]          miss_sum;
  logic [7:0]          misses_nx;

  note_chart_rom #(
    .CHART_LEN (CHART_LEN),
    .CHART_SEL (CHART_SEL)
  ) u_chart (
    .addr (beat_idx[5:0]),
    .mask (chart_mask)
  );

  assign gamestate = state;

  // Game state register.
  always_ff @(posedge clk or posedge resetbtn) begin
    if (resetbtn) begin
      state <= GS_TITLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: start advances TITLE->PLAY and END->TITLE; loss or chart completion ends PLAY.
  always_comb begin
    state_next = state;
    unique case (state)
      GS_TITLE: if (start_p)        state_next = GS_PLAY;
      GS_PLAY:  if (lose || finish) state_next = GS_END;
      GS_END:   if (start_p)        state_next = GS_TITLE;
      default:                      state_next = GS_TITLE;
    endcase
  end

  // Per-cycle PLAY datapath: beat detect, spawn arbitration, overruns and saturating sums.
  always_comb begin
    beat       = (tick_cnt == TICK_LAST);
    chart_beat = beat && (beat_idx < CHART_END);
    fire       = pending & ~lane_busy;
    held       = pending & ~fire;
    beat_mask  = chart_beat ? chart_mask : '0;
    // Only notes still waiting after this cycle's spawns collide with the new beat.
    overrun    = beat_mask & held;
    pending_nx = held | beat_mask;

    hit_add        = '0;
    hit_add[2:0]   = popcount4(hit_p);
    score_sum      = {3'b000, score} + hit_add;
    score_nx       = (score_sum > SCORE_SAT) ? '1 : score_sum[SCORE_W-1:0];

    miss_sum  = {2'b00, misses} + {7'd0, popcount4(miss_p)} + {7'd0, popcount4(overrun)};
    misses_nx = (miss_sum > 10'd255) ? 8'hff : miss_sum[7:0];

    lose   = (misses_nx >= MISS_LIMIT);
    finish = (beat_idx == CHART_END) && (pending == '0) && (lane_busy == '0);
  end

  // Counters, pending notes, spawn pulses and the loss flag.
  always_ff @(posedge clk or posedge resetbtn) begin
    if (resetbtn) begin
      tick_cnt  <= '0;
      beat_idx  <= '0;
      pending   <= '0;
      spawn     <= '0;
      score     <= '0;
      misses    <= '0;
      game_over <= 1'b0;
    end else begin
      spawn <= '0;
      unique case (state)
        GS_TITLE: begin
          if (start_p) begin
            tick_cnt  <= '0;
            beat_idx  <= '0;
            pending   <= '0;
            score     <= '0;
            misses    <= '0;
            game_over <= 1'b0;
          end
        end
        GS_PLAY: begin
          tick_cnt <= beat ? '0 : tick_cnt + 1'b1;
          if (chart_beat) begin
            beat_idx <= beat_idx + 1'b1;
          end
          pending <= pending_nx;
          score   <= score_nx;
          misses  <= misses_nx;
          if (lose) begin
            game_over <= 1'b1;
          end else if (!finish) begin
            spawn <= fire;
          end
        end
        GS_END: begin
          if (start_p) begin
            game_over <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// Randomised scoreboard bench for note_scheduler: two instances (bring-up chart and all-lanes stress chart).
module tb_note_scheduler;

  localparam int TD = 4;
  localparam int CL = 4;
  localparam int MM = 3;

  typedef struct {
    int       gs;
    int       cyc;
    int       beats;
    bit [3:0] pend;
    bit [3:0] spawn;
    int       score;
    int       misses;
    int       over;
  } ref_t;

  logic        clk;
  logic        rst;
  logic        start_p;
  logic [3:0]  busy_a, hit_a, miss_a;
  logic [1:0]  gs_a, gs_b;
  logic [3:0]  spawn_a, spawn_b;
  logic [15:0] score_a, score_b;
  logic [7:0]  misses_a, misses_b;
  logic        over_a, over_b;

  int checks = 0;
  int errors = 0;

  int   chart_a [4] = '{1, 2, 12, 0};
  int   chart_b [4] = '{15, 15, 15, 15};
  ref_t ma, mb;
  ref_t qa[$];
  ref_t qb[$];

  note_scheduler #(.TICK_DIV(TD), .CHART_LEN(CL), .MAX_MISS(MM), .SCORE_W(16), .CHART_SEL(1)) dut_a (
    .clk(clk), .resetbtn(rst), .start_p(start_p), .lane_busy(busy_a), .hit_p(hit_a), .miss_p(miss_a),
    .gamestate(gs_a), .spawn(spawn_a), .score(score_a), .misses(misses_a), .game_over(over_a)
  );

  note_scheduler #(.TICK_DIV(TD), .CHART_LEN(CL), .MAX_MISS(MM), .SCORE_W(16), .CHART_SEL(2)) dut_b (
    .clk(clk), .resetbtn(rst), .start_p(start_p), .lane_busy(4'b1111), .hit_p(4'b0000), .miss_p(4'b0000),
    .gamestate(gs_b), .spawn(spawn_b), .score(score_b), .misses(misses_b), .game_over(over_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ref_t reset_ref();
    ref_t r;
    r.gs = 1; r.cyc = 0; r.beats = 0; r.pend = '0; r.spawn = '0;
    r.score = 0; r.misses = 0; r.over = 0;
    return r;
  endfunction

  // Game rules applied to one clock edge.
  function automatic ref_t step(input ref_t m, input bit start, input bit [3:0] busy,
                                input bit [3:0] hit, input bit [3:0] miss, input int chart [4]);
    ref_t     n;
    int       add_miss;
    bit [3:0] launch;
    n        = m;
    n.spawn  = '0;
    add_miss = 0;
    launch   = '0;
    case (m.gs)
      1: if (start) begin
        n.gs = 2; n.cyc = 0; n.beats = 0; n.pend = '0; n.score = 0; n.misses = 0; n.over = 0;
      end
      2: begin
        n.cyc = m.cyc + 1;
        for (int l = 0; l < 4; l++) begin
          if (m.pend[l] && !busy[l]) begin
            launch[l] = 1'b1;
            n.pend[l] = 1'b0;
          end
          if (hit[l])  n.score = n.score + 1;
          if (miss[l]) add_miss = add_miss + 1;
        end
        if ((n.cyc % TD) == 0 && m.beats < CL) begin
          for (int l = 0; l < 4; l++) begin
            if (((chart[m.beats] >> l) & 1) != 0) begin
              if (n.pend[l]) add_miss = add_miss + 1;
              n.pend[l] = 1'b1;
            end
          end
          n.beats = m.beats + 1;
        end
        if (n.score > 65535) n.score = 65535;
        n.misses = m.misses + add_miss;
        if (n.misses > 255) n.misses = 255;
        if (n.misses >= MM) begin
          n.gs = 3; n.over = 1;
        end else if (m.beats == CL && m.pend == 0 && busy == 0) begin
          n.gs = 3;
        end else begin
          n.spawn = launch;
        end
      end
      3: if (start) begin
        n.gs = 1; n.over = 0;
      end
      default: n.gs = 1;
    endcase
    return n;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: advances on every clock edge and queues the expected outputs.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      ma = reset_ref();
      mb = reset_ref();
    end else begin
      ma = step(ma, start_p, busy_a, hit_a, miss_a, chart_a);
      mb = step(mb, start_p, 4'b1111, 4'b0000, 4'b0000, chart_b);
      qa.push_back(ma);
      qb.push_back(mb);
    end
  end

  // Monitor: compares DUT outputs just after each clock edge or reset assertion.
  initial forever begin
    ref_t ea, eb;
    @(posedge clk or posedge rst);
    #1;
    if (rst) begin
      ea = reset_ref();
      eb = reset_ref();
    end else if (qa.size() == 0 || qb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      continue;
    end else begin
      ea = qa.pop_front();
      eb = qb.pop_front();
    end
    check("a.gamestate", int'(gs_a), ea.gs);
    check("a.spawn", int'(spawn_a), int'(ea.spawn));
    check("a.score", int'(score_a), ea.score);
    check("a.misses", int'(misses_a), ea.misses);
    check("a.game_over", int'(over_a), ea.over);
    check("b.gamestate", int'(gs_b), eb.gs);
    check("b.spawn", int'(spawn_b), int'(eb.spawn));
    check("b.score", int'(score_b), eb.score);
    check("b.misses", int'(misses_b), eb.misses);
    check("b.game_over", int'(over_b), eb.over);
  end

  task automatic tick(input logic s, input logic [3:0] b, input logic [3:0] h, input logic [3:0] m);
    start_p = s;
    busy_a  = b;
    hit_a   = h;
    miss_a  = m;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rb, rh, rm;
    logic       rs;
    rst = 1'b1; start_p = 1'b0; busy_a = '0; hit_a = '0; miss_a = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) tick(1'b0, 4'h0, 4'h0, 4'h0);

    // Clean game with a couple of hits, then back to TITLE.
    tick(1'b1, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 24; i++) begin
      tick(1'b0, 4'h0, (i == 6) ? 4'b0001 : (i == 10) ? 4'b0010 : 4'h0, 4'h0);
    end
    tick(1'b1, 4'h0, 4'h0, 4'h0);
    repeat (3) tick(1'b0, 4'h0, 4'h0, 4'h0);

    // Lane 0 busy across the first beat, then an asynchronous reset mid-game.
    tick(1'b1, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, (i < 7) ? 4'b0001 : 4'h0, (i == 5) ? 4'b0100 : 4'h0, 4'h0);
    end
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    repeat (3) tick(1'b0, 4'h0, 4'h0, 4'h0);

    // Simultaneous hits and misses in PLAY, then the same pulses in TITLE.
    tick(1'b1, 4'h0, 4'h0, 4'h0);
    repeat (2) tick(1'b0, 4'h0, 4'h0, 4'h0);
    tick(1'b0, 4'h0, 4'b1111, 4'b0011);
    repeat (22) tick(1'b0, 4'h0, 4'h0, 4'h0);
    tick(1'b1, 4'h0, 4'h0, 4'h0);
    tick(1'b0, 4'h0, 4'b1111, 4'b0011);
    repeat (2) tick(1'b0, 4'h0, 4'h0, 4'h0);

    // Randomised play.
    rb = '0;
    for (int i = 0; i < 2000; i++) begin
      rs = ($urandom_range(0, 29) == 0);
      for (int l = 0; l < 4; l++) begin
        if ($urandom_range(0, 5) == 0) rb[l] = ~rb[l];
        rh[l] = ($urandom_range(0, 7) == 0);
        rm[l] = ($urandom_range(0, 99) == 0);
      end
      tick(rs, rb, rh, rm);
    end
    repeat (3) tick(1'b0, 4'h0, 4'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
